// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding, requester IDs
// and default port widths.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        SRC_F = 2'd0,
        SRC_D = 2'd1,
        SRC_X = 2'd2
    } arb_src_e;

    // One-hot winner vector (bit index == source ID) to encoded source ID.
    function automatic arb_src_e onehot_to_src(input logic [2:0] oh);
        if (oh[SRC_X]) begin
            return SRC_X;
        end else if (oh[SRC_D]) begin
            return SRC_D;
        end
        return SRC_F;
    endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational winner select: D > F > X, with X forced to win once it has starved.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic       f_req_i,
    input  logic       d_req_i,
    input  logic       x_req_i,
    input  logic       starve_i,
    output logic [2:0] win_o
);

    always_comb begin
        win_o = '0;
        if (x_req_i && starve_i) begin
            win_o[SRC_X] = 1'b1;
        end else if (d_req_i) begin
            win_o[SRC_D] = 1'b1;
        end else if (f_req_i) begin
            win_o[SRC_F] = 1'b1;
        end else if (x_req_i) begin
            win_o[SRC_X] = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (F), data (D) and debug (X) requesters.
// Define MEM_ADDR_CHECK_EN to reject accesses to the reserved top word in IDLE.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = ADDR_W_DEF,
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_LIM = 4,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              x_req,
    input  logic              x_we,
    input  logic [ADDR_W-1:0] x_addr,
    input  logic [DATA_W-1:0] x_wdata,
    output logic              f_gnt,
    output logic              d_gnt,
    output logic              x_gnt,
    output logic              rvalid,
    output logic [1:0]        rsrc,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = $clog2(STARVE_LIM + 1);

    arb_state_e        state_q, state_d;
    arb_src_e          owner_q, owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              rd_pend_q, rd_pend_d;
    logic [2:0]        gnt_q, gnt_d;
    logic              rvalid_q, rvalid_d;
    logic              err_q, err_d;
    logic [1:0]        rsrc_q, rsrc_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              starve;
    logic [2:0]        win;
    arb_src_e          win_src;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              bad_addr;

    assign starve = (starve_q == CNT_W'(STARVE_LIM));

    mem_arb_prio u_prio (
        .f_req_i  (f_req),
        .d_req_i  (d_req),
        .x_req_i  (x_req),
        .starve_i (starve),
        .win_o    (win)
    );

    assign win_src = onehot_to_src(win);

    // Fetch is read-only, so its write data is never driven onto the port.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = f_addr;
        sel_wdata = '0;
        if (win[SRC_X]) begin
            sel_we    = x_we;
            sel_addr  = x_addr;
            sel_wdata = x_wdata;
        end else if (win[SRC_D]) begin
            sel_we    = d_we;
            sel_addr  = d_addr;
            sel_wdata = d_wdata;
        end
    end

`ifdef MEM_ADDR_CHECK_EN
    // Top word is the halt vector and may not be accessed through the port.
    assign bad_addr = (sel_addr == {ADDR_W{1'b1}});
`else
    assign bad_addr = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        timer_d     = timer_q;
        starve_d    = starve_q;
        rbuf_d      = rbuf_q;
        rd_pend_d   = rd_pend_q;
        gnt_d       = '0;
        rvalid_d    = 1'b0;
        err_d       = 1'b0;
        rsrc_d      = rsrc_q;
        rdata_d     = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (!x_req) begin
                    starve_d = '0;
                end
                if (|win) begin
                    gnt_d   = win;
                    owner_d = win_src;
                    if (win[SRC_X]) begin
                        starve_d = '0;
                    end else if (x_req && !starve) begin
                        starve_d = starve_q + CNT_W'(1);
                    end
                    if (bad_addr) begin
                        err_d  = 1'b1;
                        rsrc_d = win_src;
                    end else begin
                        mem_en_d    = 1'b1;
                        mem_we_d    = sel_we;
                        mem_addr_d  = sel_addr;
                        mem_wdata_d = sel_wdata;
                        timer_d     = '0;
                        state_d     = ACCESS;
                    end
                end
            end
            ACCESS: begin
                // A ready on the final timer cycle still completes the access.
                if (mem_ready) begin
                    mem_en_d  = 1'b0;
                    mem_we_d  = 1'b0;
                    rd_pend_d = !mem_we_q;
                    if (!mem_we_q) begin
                        rbuf_d = mem_rdata;
                    end
                    state_d = DONE;
                end else if (timer_q == TMR_W'(TIMEOUT)) begin
                    err_d    = 1'b1;
                    rsrc_d   = owner_q;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                if (rd_pend_q) begin
                    rvalid_d  = 1'b1;
                    rsrc_d    = owner_q;
                    rdata_d   = rbuf_q;
                    rd_pend_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            owner_q     <= SRC_F;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            timer_q     <= '0;
            starve_q    <= '0;
            rbuf_q      <= '0;
            rd_pend_q   <= 1'b0;
            gnt_q       <= '0;
            rvalid_q    <= 1'b0;
            err_q       <= 1'b0;
            rsrc_q      <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            timer_q     <= timer_d;
            starve_q    <= starve_d;
            rbuf_q      <= rbuf_d;
            rd_pend_q   <= rd_pend_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            err_q       <= err_d;
            rsrc_q      <= rsrc_d;
            rdata_q     <= rdata_d;
        end
    end

    assign f_gnt     = gnt_q[SRC_F];
    assign d_gnt     = gnt_q[SRC_D];
    assign x_gnt     = gnt_q[SRC_X];
    assign rvalid    = rvalid_q;
    assign rsrc      = rsrc_q;
    assign rdata     = rdata_q;
    assign err       = err_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-schedule model of the arbiter and a behavioural memory.
module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 15;
    localparam int STARVE_LIM = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        f_req, d_req, d_we, x_req, x_we;
    logic [4:0]  f_addr, d_addr, x_addr;
    logic [15:0] d_wdata, x_wdata;
    logic        f_gnt, d_gnt, x_gnt, rvalid, err, mem_en, mem_we, mem_ready;
    logic [1:0]  rsrc;
    logic [15:0] rdata, mem_wdata, mem_rdata;
    logic [4:0]  mem_addr;

    always #5 clock = ~clock;

    mem_port_arbiter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .x_req     (x_req),
        .x_we      (x_we),
        .x_addr    (x_addr),
        .x_wdata   (x_wdata),
        .f_gnt     (f_gnt),
        .d_gnt     (d_gnt),
        .x_gnt     (x_gnt),
        .rvalid    (rvalid),
        .rsrc      (rsrc),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    int checks = 0;
    int failures = 0;
    int edge_n = 0;

    // Model: memory contents plus the schedule of the one access in flight.
    logic [15:0] mem [32];
    int          next_arb, starve, owner, gstart, end_e, rv_edge, acc_lat, lat_sel;
    bit          busy, acc_ok, acc_we, keep_alt;
    logic [4:0]  acc_addr;
    logic [15:0] acc_wdata, cap;
    bit          e_gnt [3];
    bit          e_rvalid, e_err;
    logic [1:0]  e_rsrc;
    logic [15:0] e_rdata;
    int          last_gnt_edge [3];
    int          last_rv_edge, last_err_edge, total_gnts, x_idx;
    int          base, base_gnt, prev_rv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at edge %0d", name, act, exp, edge_n);
        end
    endtask

    function automatic int pick_lat();
        int r;
        if (lat_sel >= 0) return lat_sel;
        r = int'($urandom_range(9));
        if (r < 6) return int'($urandom_range(2));
        if (r < 8) return int'($urandom_range(TIMEOUT, TIMEOUT - 2));
        return TIMEOUT + 1;
    endfunction

    task automatic model_reset();
        busy     = 0;
        rv_edge  = -1;
        starve   = 0;
        e_rsrc   = '0;
        e_rdata  = '0;
        e_rvalid = 0;
        e_err    = 0;
        for (int i = 0; i < 3; i++) e_gnt[i] = 0;
        next_arb  = edge_n + 1;
        mem_ready = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic model_edge();
        int w;
        bit bad;
        for (int i = 0; i < 3; i++) e_gnt[i] = 0;
        e_rvalid = 0;
        e_err    = 0;
        if (busy && edge_n == end_e) begin
            busy = 0;
            if (acc_ok) begin
                if (acc_we) mem[acc_addr] = acc_wdata;
                else rv_edge = edge_n + 1;
                next_arb = edge_n + 2;
            end else begin
                e_err = 1; e_rsrc = 2'(owner); last_err_edge = edge_n;
                next_arb = edge_n + 1;
            end
        end
        if (edge_n == rv_edge) begin
            e_rvalid = 1; e_rsrc = 2'(owner); e_rdata = cap; last_rv_edge = edge_n;
        end
        if (!busy && edge_n >= next_arb) begin
            if (!x_req) starve = 0;
            w = -1;
            if (x_req && starve == STARVE_LIM) w = 2;
            else if (d_req) w = 1;
            else if (f_req) w = 0;
            else if (x_req) w = 2;
            if (w >= 0) begin
                e_gnt[w] = 1; owner = w; last_gnt_edge[w] = edge_n; total_gnts++;
                if (w == 2) begin
                    starve = 0; x_idx = total_gnts;
                end else if (x_req && starve < STARVE_LIM) begin
                    starve++;
                end
                case (w)
                    0: begin acc_we = 0; acc_addr = f_addr; acc_wdata = '0; end
                    1: begin acc_we = d_we; acc_addr = d_addr; acc_wdata = d_wdata; end
                    default: begin acc_we = x_we; acc_addr = x_addr; acc_wdata = x_wdata; end
                endcase
`ifdef MEM_ADDR_CHECK_EN
                bad = (acc_addr == 5'd31);
`else
                bad = 0;
`endif
                if (bad) begin
                    e_err = 1; e_rsrc = 2'(w); last_err_edge = edge_n; next_arb = edge_n + 1;
                end else begin
                    busy    = 1;
                    gstart  = edge_n;
                    acc_lat = pick_lat();
                    acc_ok  = (acc_lat <= TIMEOUT);
                    end_e   = acc_ok ? edge_n + acc_lat + 1 : edge_n + TIMEOUT + 1;
                end
            end
        end
    endtask

    task automatic compare();
        chk("f_gnt", f_gnt, e_gnt[0]);
        chk("d_gnt", d_gnt, e_gnt[1]);
        chk("x_gnt", x_gnt, e_gnt[2]);
        chk("rvalid", rvalid, e_rvalid);
        chk("err", err, e_err);
        chk("rsrc", rsrc, e_rsrc);
        chk("rdata", rdata, e_rdata);
        chk("mem_en", mem_en, busy);
        if (busy) begin
            chk("mem_we", mem_we, acc_we);
            chk("mem_addr", mem_addr, acc_addr);
            if (acc_we) chk("mem_wdata", mem_wdata, acc_wdata);
        end
    endtask

    // Memory side for the cycle that follows the edge just processed.
    task automatic drive_mem();
        if (busy && (edge_n - gstart) == acc_lat) begin
            mem_ready = 1'b1;
            mem_rdata = acc_we ? 16'($urandom) : mem[acc_addr];
            cap       = mem_rdata;
        end else begin
            mem_ready = busy ? 1'b0 : 1'($urandom_range(1));
            mem_rdata = 16'($urandom);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        edge_n++;
        model_edge();
        @(negedge clock);
        compare();
        drive_mem();
        if (e_gnt[0]) begin f_req = 0; if (keep_alt) d_req = 1; end
        if (e_gnt[1]) begin d_req = 0; if (keep_alt) f_req = 1; end
        if (e_gnt[2]) x_req = 0;
    endtask

    task automatic rand_reqs();
        if (!f_req && $urandom_range(3) == 0) begin
            f_req = 1; f_addr = 5'($urandom);
        end else if (f_req && $urandom_range(19) == 0) begin
            f_req = 0;
        end
        if (!d_req && $urandom_range(3) == 0) begin
            d_req = 1; d_we = 1'($urandom); d_addr = 5'($urandom); d_wdata = 16'($urandom);
        end else if (d_req && $urandom_range(19) == 0) begin
            d_req = 0;
        end
        if (!x_req && $urandom_range(5) == 0) begin
            x_req = 1; x_we = 1'($urandom); x_addr = 5'($urandom); x_wdata = 16'($urandom);
        end else if (x_req && $urandom_range(29) == 0) begin
            x_req = 0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_f_gnt"}, f_gnt, 0);
        chk({tag, "_d_gnt"}, d_gnt, 0);
        chk({tag, "_x_gnt"}, x_gnt, 0);
        chk({tag, "_rvalid"}, rvalid, 0);
        chk({tag, "_err"}, err, 0);
        chk({tag, "_rsrc"}, rsrc, 0);
        chk({tag, "_rdata"}, rdata, 0);
        chk({tag, "_mem_en"}, mem_en, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_wdata"}, mem_wdata, 0);
    endtask

    initial begin
        reset_n = 0;
        f_req = 0; d_req = 0; x_req = 0; d_we = 0; x_we = 0;
        f_addr = '0; d_addr = '0; x_addr = '0; d_wdata = '0; x_wdata = '0;
        mem_ready = 0; mem_rdata = '0; cap = '0;
        keep_alt = 0; lat_sel = 0; total_gnts = 0; x_idx = -1;
        last_rv_edge = -100; last_err_edge = -100;
        for (int i = 0; i < 3; i++) last_gnt_edge[i] = -100;
        for (int i = 0; i < 32; i++) mem[i] = 16'($urandom);
        #3;
        check_zero("reset");
        @(negedge clock);
        reset_n = 1;
        model_reset();

        // Single fetch read with immediate ready.
        mem[3] = 16'hA5A5; base = edge_n;
        f_req = 1; f_addr = 5'd3;
        repeat (5) tick();
        chk("t1_fgnt_edge", last_gnt_edge[0] - base, 1);
        chk("t1_rv_edge", last_rv_edge - base, 3);
        chk("t1_rdata", rdata, 16'hA5A5);
        chk("t1_rsrc", rsrc, 0);

        // D beats F when raised together; F follows one access period later.
        base = edge_n;
        f_req = 1; f_addr = 5'd2;
        d_req = 1; d_we = 1; d_addr = 5'd7; d_wdata = 16'h1234;
        repeat (8) tick();
        chk("t2_dgnt_edge", last_gnt_edge[1] - base, 1);
        chk("t2_fgnt_edge", last_gnt_edge[0] - base, 4);
        chk("t2_mem7", mem[7], 16'h1234);

        // X starves while D and F alternate, then is forced through.
        base_gnt = total_gnts; x_idx = -1; keep_alt = 1;
        x_req = 1; x_we = 0; x_addr = 5'd4;
        d_req = 1; d_we = 0; d_addr = 5'd5;
        f_req = 1; f_addr = 5'd6;
        for (int i = 0; i < 60 && x_idx < 0; i++) tick();
        keep_alt = 0; d_req = 0; f_req = 0;
        chk("t3_x_grant_index", x_idx - base_gnt, 5);
        chk("t3_starve_cleared", starve, 0);
        repeat (6) tick();

        // Hung memory: abort after the full timeout window.
        lat_sel = 99; prev_rv = last_rv_edge; base = edge_n;
        d_req = 1; d_we = 0; d_addr = 5'd8;
        repeat (20) tick();
        chk("t4_err_delay", last_err_edge - last_gnt_edge[1], 16);
        chk("t4_no_rvalid", last_rv_edge, prev_rv);
        chk("t4_rsrc", rsrc, 1);

        // Ready on the last allowed cycle still succeeds.
        lat_sel = TIMEOUT; prev_rv = last_err_edge;
        f_req = 1; f_addr = 5'd3;
        repeat (20) tick();
        chk("t5_rv_delay", last_rv_edge - last_gnt_edge[0], TIMEOUT + 2);
        chk("t5_no_err", last_err_edge, prev_rv);
        chk("t5_rdata", rdata, 16'hA5A5);

        // Reset asserted mid-access clears outputs at once.
        lat_sel = 10;
        d_req = 1; d_we = 0; d_addr = 5'd9;
        repeat (3) tick();
        #2;
        reset_n = 0;
        d_req = 0;
        #1;
        check_zero("t6_midreset");
        @(posedge clock);
        edge_n++;
        @(negedge clock);
        reset_n = 1;
        model_reset();
        mem[9] = 16'h0F0F; lat_sel = 1; base = edge_n;
        d_req = 1; d_we = 0; d_addr = 5'd9;
        repeat (6) tick();
        chk("t6_rv_edge", last_rv_edge - base, 4);
        chk("t6_rdata", rdata, 16'h0F0F);

        // Reserved top address.
        lat_sel = 0; mem[31] = 16'hBEEF; prev_rv = last_rv_edge;
        d_req = 1; d_we = 0; d_addr = 5'd31;
        repeat (5) tick();
`ifdef MEM_ADDR_CHECK_EN
        chk("t7_err_same_edge", last_err_edge - last_gnt_edge[1], 0);
        chk("t7_no_rvalid", last_rv_edge, prev_rv);
`else
        chk("t7_rv_delay", last_rv_edge - last_gnt_edge[1], 2);
        chk("t7_rdata", rdata, 16'hBEEF);
`endif

        // Randomized traffic with random wait states and timeouts.
        lat_sel = -1;
        repeat (2500) begin
            rand_reqs();
            tick();
        end
        f_req = 0; d_req = 0; x_req = 0;
        repeat (25) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 16-bit memory port between three requesters: instruction fetch (F), operand data read/write (D), and debug/loader (X).
- Sits between the microcoded processor datapath (fetch into irf, operand access via di/do) and the memory array.
- Sequences each access through a small FSM, tolerates wait-stated memory, aborts hung accesses, and returns read data with a valid pulse.

Parameters:
- ADDR_W, 5, memory address width (32-word memory).
- DATA_W, 16, data width.
- STARVE_LIM, 4, consecutive X losses before X is forced to win.
- TIMEOUT, 15, max cycles to wait for mem_ready before abort.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- f_req  in  1  fetch request (read only)
- f_addr  in  ADDR_W  fetch address
- d_req  in  1  data request
- d_we  in  1  data write enable (1 = write)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  data write value
- x_req, x_we, x_addr, x_wdata  in  1/1/ADDR_W/DATA_W  debug port, same meaning as the data port
- f_gnt, d_gnt, x_gnt  out  1  one-cycle grant pulse per requester
- rvalid  out  1  one-cycle read-data-valid pulse
- rsrc  out  2  owner of rvalid/err (0=F, 1=D, 2=X)
- rdata  out  DATA_W  read data, held until the next rvalid
- err  out  1  one-cycle abort pulse (timeout or bad address)
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_ready  in  1  memory completes the access this cycle

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, starve counter 0, timer 0. Any access in flight is dropped with no gnt, rvalid or err.
- Requester rule: hold req, we, addr and wdata stable until the gnt pulse. A requester that drops req before gnt loses its request silently.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - Arbitrates when any req is high. Priority is D > F > X, except X wins when starve_cnt == STARVE_LIM.
  - Next edge: latches the winner's we, addr and wdata; pulses the winner's gnt; asserts mem_en; goes to ACCESS; timer = 0.
- ACCESS:
  - mem_en, mem_we, mem_addr and mem_wdata are held constant.
  - mem_ready=1: for a read, rdata <= mem_rdata and rvalid pulses next cycle. For a write, rvalid stays 0. mem_en drops; go to DONE.
  - mem_ready=0: timer increments. When timer == TIMEOUT: err pulses, rsrc = owner, mem_en drops, go to IDLE with no rvalid.
- DONE: one bubble cycle, then IDLE. Minimum access period is 3 cycles.
- Starve counter:
  - Increments (saturating at STARVE_LIM) on each grant to F or D while x_req=1.
  - Clears on an X grant, or whenever x_req=0 in IDLE.
- rsrc is valid in the cycle of rvalid or err; otherwise it holds its last value.
- Simultaneous events:
  - mem_ready arriving on the same cycle the timer hits TIMEOUT counts as success; no err.
  - New requests arriving during ACCESS or DONE wait; they are not queued beyond req being held.
- mem_ready seen in IDLE or DONE is ignored.

Optional Feature:
- Macro: MEM_ADDR_CHECK_EN.
- Defined: a winning request with addr >= 2**ADDR_W - 1 (top word reserved as halt vector) is rejected in IDLE. gnt pulses, err pulses on the same edge, mem_en stays 0, FSM stays in IDLE.
- Undefined: every address is forwarded to memory unchanged.

Decomposition:
- Shared package mem_arb_pkg holds the state encoding (IDLE=2'b00, ACCESS=2'b01, DONE=2'b10), the source IDs (SRC_F=0, SRC_D=1, SRC_X=2), and the DATA_W/ADDR_W defaults.
- One natural sub-module, mem_arb_prio: combinational priority select with starvation override. Inputs are the three reqs and the starve flag; output is the one-hot winner.

Test Plan:
- Single F read of addr 3, m[3]=16'hA5A5, mem_ready on the first ACCESS cycle -> f_gnt at edge 1, rvalid with rdata=16'hA5A5 and rsrc=0 at edge 3.
- f_req and d_req (write 16'h1234 to addr 7) raised in the same cycle -> d_gnt first and m[7]=16'h1234; f_gnt 3 cycles later.
- x_req held while D and F alternate continuously -> x_gnt no later than the 5th grant, starve_cnt back to 0.
- mem_ready tied low with TIMEOUT=15 -> err pulse 16 cycles after gnt, rsrc = owner, no rvalid, FSM returns to IDLE.
- reset_n dropped mid-ACCESS -> all outputs 0 immediately; after release a fresh D read completes normally.
- MEM_ADDR_CHECK_EN defined, d read at addr 31 -> d_gnt and err on the same edge, mem_en never asserted.
